// File: rtl/grf_scoreboard.sv
// grf_scoreboard: register-file hazard scoreboard that produces stall and operand forwarding selects
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   id_valid             a real instruction is present in ID
//   id_rs, id_rt         source register numbers read in ID
//   id_rs_tuse/rt_tuse   cycles until each operand is consumed (3 = unused)
//   id_we, id_wa         ID instruction writes register id_wa
//   id_tnew              cycles until the result exists, counted from entry into E
//   e_clr                kill the instruction entering E this cycle
//   stall                freeze PC/IF/ID and bubble E
//   fwd_rs_sel/rt_sel    operand source: 0 GRF, 1 E, 2 M, 3 W
//   stall_count          saturating count of stall cycles
// Macro GRF_BYPASS_EN: a W-stage hit reads the GRF (sel 0) via its write-through.
module grf_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_rs_tuse,
  input  logic [1:0]  id_rt_tuse,
  input  logic        id_we,
  input  logic [4:0]  id_wa,
  input  logic [1:0]  id_tnew,
  input  logic        e_clr,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [31:0] stall_count
);
  // index 0 = E, 1 = M, 2 = W
  logic [2:0]  v_q, v_d;
  logic [4:0]  wa_q [3];
  logic [4:0]  wa_d [3];
  logic [1:0]  tn_q [3];
  logic [1:0]  tn_d [3];
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  rs_m, rt_m;
  logic [1:0]  rs_st, rt_st, rs_tn, rt_tn;
  logic        rs_hz, rt_hz;

  function automatic logic [1:0] dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic [1:0] nearest(input logic [2:0] m);
    return m[0] ? 2'd1 : m[1] ? 2'd2 : m[2] ? 2'd3 : 2'd0;
  endfunction

  // forwarding only matters when the nearest producer is ready by the time the operand is used
  function automatic logic [1:0] to_sel(input logic [1:0] st, input logic hz);
`ifdef GRF_BYPASS_EN
    return (hz || st == 2'd3) ? 2'd0 : st;
`else
    return hz ? 2'd0 : st;
`endif
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_m
    assign rs_m[i] = v_q[i] && wa_q[i] == id_rs && id_rs != 5'd0 && id_rs_tuse != 2'd3;
    assign rt_m[i] = v_q[i] && wa_q[i] == id_rt && id_rt != 5'd0 && id_rt_tuse != 2'd3;
  end

  always_comb begin
    rs_st = nearest(rs_m);
    rt_st = nearest(rt_m);
    rs_tn = rs_m[0] ? tn_q[0] : rs_m[1] ? tn_q[1] : rs_m[2] ? tn_q[2] : 2'd0;
    rt_tn = rt_m[0] ? tn_q[0] : rt_m[1] ? tn_q[1] : rt_m[2] ? tn_q[2] : 2'd0;
    rs_hz = rs_st != 2'd0 && rs_tn > id_rs_tuse;
    rt_hz = rt_st != 2'd0 && rt_tn > id_rt_tuse;
    stall = id_valid & (rs_hz | rt_hz);
    fwd_rs_sel = to_sel(rs_st, rs_hz);
    fwd_rt_sel = to_sel(rt_st, rt_hz);
  end

  always_comb begin
    v_d = {v_q[1:0], id_valid & id_we & (id_wa != 5'd0) & ~stall & ~e_clr};
    wa_d = '{id_wa, wa_q[0], wa_q[1]};
    tn_d = '{id_tnew, dec(tn_q[0]), dec(tn_q[1])};
    cnt_d = (stall && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      wa_q <= '{default: '0};
      tn_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      v_q <= v_d;
      wa_q <= wa_d;
      tn_q <= tn_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: scenario tests for the hazard scoreboard with a queue of expected outputs
module tb_grf_scoreboard;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wa = '0;
  logic [1:0]  id_rs_tuse = 2'd3, id_rt_tuse = 2'd3, id_tnew = '0;
  logic        id_we = 1'b0, e_clr = 1'b0;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_count;
  int          total = 0, bad = 0;
  logic [4:0]  sb [$];

`ifdef GRF_BYPASS_EN
  localparam logic [1:0] W_SEL = 2'd0;
`else
  localparam logic [1:0] W_SEL = 2'd3;
`endif

  typedef struct packed {
    logic v; logic [4:0] rs; logic [1:0] rstu; logic [4:0] rt; logic [1:0] rttu;
    logic we; logic [4:0] wa; logic [1:0] tn;
  } row_t;

  grf_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse), .id_we(id_we), .id_wa(id_wa),
    .id_tnew(id_tnew), .e_clr(e_clr), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic row_t wr(input logic [4:0] wa, input logic [1:0] tn);
    return '{v: 1'b1, rs: 5'd0, rstu: 2'd3, rt: 5'd0, rttu: 2'd3, we: 1'b1, wa: wa, tn: tn};
  endfunction

  function automatic row_t rd(input logic [4:0] rs, input logic [1:0] rstu, input logic [4:0] rt, input logic [1:0] rttu);
    return '{v: 1'b1, rs: rs, rstu: rstu, rt: rt, rttu: rttu, we: 1'b0, wa: 5'd0, tn: 2'd0};
  endfunction

  function automatic row_t nop();
    return '{v: 1'b0, rs: 5'd0, rstu: 2'd3, rt: 5'd0, rttu: 2'd3, we: 1'b0, wa: 5'd0, tn: 2'd0};
  endfunction

  // drives one ID cycle and queues the expected {stall, rs_sel, rt_sel}; sels are ignored on stall rows
  task automatic drive(input row_t r, input logic clr, input logic [4:0] exp);
    @(negedge clk);
    id_valid = r.v; id_rs = r.rs; id_rs_tuse = r.rstu; id_rt = r.rt; id_rt_tuse = r.rttu;
    id_we = r.we; id_wa = r.wa; id_tnew = r.tn; e_clr = clr;
    sb.push_back(exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    id_valid = 1'b0; id_we = 1'b0; e_clr = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] e, got;
    do_reset();
    drive(rd(5'd8, 2'd0, 5'd9, 2'd0), 1'b0, 5'b0_00_00);
    #1 e = sb.pop_front();
    got = {stall, fwd_rs_sel, fwd_rt_sel};
    total++;
    if (got !== e) begin bad++; $display("FAIL reset_outputs got %b want %b", got, e); end
    total++;
    if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count got %0d want 0", stall_count); end
  endtask

  task automatic test_load_use();
    row_t r [3];
    logic [4:0] x [3];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd8, 2'd2), rd(5'd8, 2'd1, 5'd0, 2'd3), rd(5'd8, 2'd1, 5'd0, 2'd3)};
    x = '{5'b0_00_00, 5'b1_00_00, 5'b0_10_00};
    for (int i = 0; i < 3; i++) begin
      drive(r[i], 1'b0, x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      if (e[4]) got[3:0] = 4'b0;
      total++;
      if (got !== e) begin bad++; $display("FAIL load_use[%0d] got %b want %b", i, got, e); end
    end
    @(posedge clk);
    #1 total++;
    if (stall_count !== 32'd1) begin bad++; $display("FAIL load_use_count got %0d want 1", stall_count); end
  endtask

  task automatic test_alu();
    row_t r [5];
    logic [4:0] x [5];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd9, 2'd1), rd(5'd9, 2'd1, 5'd0, 2'd3), rd(5'd0, 2'd3, 5'd9, 2'd0),
          wr(5'd11, 2'd2), rd(5'd11, 2'd2, 5'd0, 2'd3)};
    x = '{5'b0_00_00, 5'b0_01_00, 5'b0_00_10, 5'b0_00_00, 5'b0_01_00};
    for (int i = 0; i < 5; i++) begin
      drive(r[i], 1'b0, x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      if (e[4]) got[3:0] = 4'b0;
      total++;
      if (got !== e) begin bad++; $display("FAIL alu[%0d] got %b want %b", i, got, e); end
    end
  endtask

  task automatic test_priority();
    row_t r [4];
    logic [4:0] x [4];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd5, 2'd0), wr(5'd5, 2'd0), nop(), rd(5'd0, 2'd3, 5'd5, 2'd0)};
    x = '{5'b0_00_00, 5'b0_00_00, 5'b0_00_00, 5'b0_00_10};
    for (int i = 0; i < 4; i++) begin
      drive(r[i], 1'b0, x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      total++;
      if (got !== e) begin bad++; $display("FAIL priority[%0d] got %b want %b", i, got, e); end
    end
  endtask

  task automatic test_zero();
    row_t r [4];
    logic [4:0] x [4];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd0, 2'd2), rd(5'd0, 2'd0, 5'd0, 2'd0), wr(5'd3, 2'd2), rd(5'd3, 2'd3, 5'd3, 2'd3)};
    x = '{5'b0_00_00, 5'b0_00_00, 5'b0_00_00, 5'b0_00_00};
    for (int i = 0; i < 4; i++) begin
      drive(r[i], 1'b0, x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      total++;
      if (got !== e) begin bad++; $display("FAIL zero[%0d] got %b want %b", i, got, e); end
    end
  endtask

  task automatic test_wstage();
    row_t r [4];
    logic [4:0] x [4];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd7, 2'd2), nop(), rd(5'd7, 2'd0, 5'd0, 2'd3), rd(5'd7, 2'd0, 5'd0, 2'd3)};
    x = '{5'b0_00_00, 5'b0_00_00, 5'b1_00_00, {1'b0, W_SEL, 2'b00}};
    for (int i = 0; i < 4; i++) begin
      drive(r[i], 1'b0, x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      if (e[4]) got[3:0] = 4'b0;
      total++;
      if (got !== e) begin bad++; $display("FAIL wstage[%0d] got %b want %b", i, got, e); end
    end
  endtask

  task automatic test_eclr();
    row_t r [7];
    logic c [7];
    logic [4:0] x [7];
    logic [4:0] e, got;
    do_reset();
    r = '{wr(5'd4, 2'd2), rd(5'd4, 2'd0, 5'd0, 2'd3), rd(5'd4, 2'd0, 5'd0, 2'd3), rd(5'd4, 2'd0, 5'd0, 2'd3),
          wr(5'd6, 2'd2), rd(5'd6, 2'd0, 5'd0, 2'd3), rd(5'd0, 2'd3, 5'd6, 2'd0)};
    c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    x = '{5'b0_00_00, 5'b1_00_00, 5'b1_00_00, {1'b0, W_SEL, 2'b00}, 5'b0_00_00, 5'b0_00_00, 5'b0_00_00};
    for (int i = 0; i < 7; i++) begin
      drive(r[i], c[i], x[i]);
      #1 e = sb.pop_front();
      got = {stall, fwd_rs_sel, fwd_rt_sel};
      if (e[4]) got[3:0] = 4'b0;
      total++;
      if (got !== e) begin bad++; $display("FAIL eclr[%0d] got %b want %b", i, got, e); end
    end
    @(posedge clk);
    #1 total++;
    if (stall_count !== 32'd2) begin bad++; $display("FAIL eclr_count got %0d want 2", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    logic [4:0] e, got;
    do_reset();
    drive(wr(5'd8, 2'd2), 1'b0, 5'b0_00_00);
    #1 e = sb.pop_front();
    drive(rd(5'd8, 2'd0, 5'd8, 2'd0), 1'b0, 5'b1_00_00);
    #1 e = sb.pop_front();
    total++;
    if (stall !== e[4]) begin bad++; $display("FAIL mid_stall_pre got %b want %b", stall, e[4]); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(rd(5'd8, 2'd0, 5'd8, 2'd0), 1'b0, 5'b0_00_00);
    #1 e = sb.pop_front();
    got = {stall, fwd_rs_sel, fwd_rt_sel};
    total++;
    if (got !== e) begin bad++; $display("FAIL mid_stall_post got %b want %b", got, e); end
    total++;
    if (stall_count !== 32'd0) begin bad++; $display("FAIL mid_stall_count got %0d want 0", stall_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu();
    test_priority();
    test_zero();
    test_wstage();
    test_eclr();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
